led_sequencer: RTL and testbench

Memory-mapped LED pattern sequencer on the processor I/O bus. Software loads up to four LED patterns and a step period, then enables the block. It steps through the patterns autonomously. For each step it requests the I/O bus from the external bus arbiter and issues a single write cycle to the LED device register, so the CPU does not have to poll.

---
 rtl/led_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_led_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: memory-mapped LED pattern sequencer that steps through up to four
// patterns and writes each one to the LED register over the I/O bus. Define LED_SEQ_IRQ_EN for the wrap interrupt.
module led_sequencer #(
    parameter int              BITS      = 32,
    parameter logic [BITS-1:0] BASE      = 32'hF0000100,
    parameter logic [BITS-1:0] LED_ADDR  = 32'hF0000000,
    parameter int              LED_WIDTH = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [BITS-1:0] memAddr,
    input  logic [BITS-1:0] dataBusIn,
    output logic [BITS-1:0] dataBusOut,
    output logic            busReq,
    input  logic            busGnt,
    output logic [BITS-1:0] mAddr,
    output logic            mWe,
    output logic [BITS-1:0] mData,
    output logic            irq
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WRITE,
        COUNT
    } SeqState;

    localparam logic [BITS-1:0] ONE = BITS'(1);

    SeqState                         state;
    logic                            en;
    logic [1:0]                      last;
    logic [1:0]                      idx;
    logic                            wrap;
    logic [BITS-1:0]                 period;
    logic [BITS-1:0]                 cnt;
    logic [3:0][LED_WIDTH-1:0]       pat;
`ifdef LED_SEQ_IRQ_EN
    logic                            irqEn;
`endif

    logic                            hitCtrl;
    logic                            hitPeriod;
    logic [3:0]                      hitPat;
    logic                            ctrlWrite;
    logic                            wrapSet;
    logic [BITS-1:0]                 ctrlWord;

    function automatic logic [BITS-1:0] regAddr(input int unsigned offset);
        return BASE + BITS'(offset);
    endfunction

    always_comb begin
        hitCtrl   = (memAddr == regAddr(0));
        hitPeriod = (memAddr == regAddr(4));
        for (int i = 0; i < 4; i++) begin
            hitPat[i] = (memAddr == regAddr(8 + 4 * i));
        end
    end

    assign ctrlWrite = we && hitCtrl;

    // A wrap happens when the counting step expires while sitting at (or beyond) LAST.
    assign wrapSet = en && (state == COUNT) && (cnt == '0) && (idx >= last);

    always_comb begin
        ctrlWord      = '0;
        ctrlWord[0]   = en;
        ctrlWord[2:1] = last;
        ctrlWord[5:4] = idx;
        ctrlWord[8]   = wrap;
`ifdef LED_SEQ_IRQ_EN
        ctrlWord[9]   = irqEn;
`endif
    end

    always_comb begin
        dataBusOut = '0;
        if (!we) begin
            if (hitCtrl) begin
                dataBusOut = ctrlWord;
            end else if (hitPeriod) begin
                dataBusOut = period;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (hitPat[i]) begin
                        dataBusOut = BITS'(pat[i]);
                    end
                end
            end
        end
    end

    // Software-visible registers; a wrap on the same edge as a clear leaves WRAP set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            last   <= 2'd0;
            wrap   <= 1'b0;
            period <= '0;
            pat    <= '0;
`ifdef LED_SEQ_IRQ_EN
            irqEn  <= 1'b0;
`endif
        end else begin
            if (ctrlWrite) begin
                en   <= dataBusIn[0];
                last <= dataBusIn[2:1];
`ifdef LED_SEQ_IRQ_EN
                irqEn <= dataBusIn[9];
`endif
            end
            if (wrapSet) begin
                wrap <= 1'b1;
            end else if (ctrlWrite && dataBusIn[8]) begin
                wrap <= 1'b0;
            end
            if (we && hitPeriod) begin
                period <= dataBusIn;
            end
            for (int i = 0; i < 4; i++) begin
                if (we && hitPat[i]) begin
                    pat[i] <= dataBusIn[LED_WIDTH-1:0];
                end
            end
        end
    end

    // Step sequencer; clearing EN returns to IDLE from any state and keeps idx for readback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= 2'd0;
            cnt    <= '0;
            busReq <= 1'b0;
            mWe    <= 1'b0;
            mAddr  <= '0;
            mData  <= '0;
        end else if (!en) begin
            state  <= IDLE;
            busReq <= 1'b0;
            mWe    <= 1'b0;
            mAddr  <= '0;
            mData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx    <= 2'd0;
                    state  <= REQ;
                    busReq <= 1'b1;
                end
                REQ: begin
                    if (busGnt) begin
                        state <= WRITE;
                        mWe   <= 1'b1;
                        mAddr <= LED_ADDR;
                        mData <= BITS'(pat[idx]);
                    end
                end
                WRITE: begin
                    state  <= COUNT;
                    busReq <= 1'b0;
                    mWe    <= 1'b0;
                    mAddr  <= '0;
                    mData  <= '0;
                    cnt    <= (period == '0) ? '0 : period - ONE;
                end
                COUNT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else begin
                        idx    <= (idx >= last) ? 2'd0 : idx + 2'd1;
                        state  <= REQ;
                        busReq <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef LED_SEQ_IRQ_EN
    assign irq = wrap & irqEn;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and randomized checks of led_sequencer against a
// step-timing reference model built from the register/sequencing rules.
module tb_led_sequencer;

    localparam logic [31:0] BASE     = 32'hF0000100;
    localparam logic [31:0] LED_ADDR = 32'hF0000000;
`ifdef LED_SEQ_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [31:0] memAddr = '0;
    logic [31:0] dataBusIn = '0;
    logic [31:0] dataBusOut;
    logic        busReq;
    logic        busGnt = 1'b0;
    logic [31:0] mAddr;
    logic        mWe;
    logic [31:0] mData;
    logic        irq;

    led_sequencer dut (
        .clk(clk), .reset(reset), .we(we), .memAddr(memAddr),
        .dataBusIn(dataBusIn), .dataBusOut(dataBusOut), .busReq(busReq),
        .busGnt(busGnt), .mAddr(mAddr), .mWe(mWe), .mData(mData), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Grant driver: value present during cycle c is logged at gntLog[c].
    int gntMode = 0;
    bit gntLog[8192];
    always @(posedge clk) begin
        #2;
        case (gntMode)
            0:       busGnt = 1'b0;
            1:       busGnt = 1'b1;
            default: busGnt = ($urandom_range(0, 9) < 7);
        endcase
        if (cyc < 8192) gntLog[cyc] = busGnt;
    end

    int          wrCyc[$];
    logic [31:0] wrData[$];
    logic [31:0] wrAddr[$];
    bit          idleBad = 1'b0;
    bit          irqSeen = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            if (mWe === 1'b1) begin
                wrCyc.push_back(cyc);
                wrData.push_back(mData);
                wrAddr.push_back(mAddr);
            end else if (mAddr !== 32'd0 || mData !== 32'd0) begin
                idleBad = 1'b1;
            end
            if (irq === 1'b1) irqSeen = 1'b1;
        end
    end

    logic [9:0] refPat[4];
    int         refLast = 0;
    int         refPeriod = 0;
    bit         refWrap = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, output int landEdge);
        @(negedge clk);
        we        = 1'b1;
        memAddr   = addr;
        dataBusIn = data;
        landEdge  = cyc + 1;
        @(negedge clk);
        we        = 1'b0;
        memAddr   = '0;
        dataBusIn = '0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        we      = 1'b0;
        memAddr = addr;
        #1;
        data    = dataBusOut;
    endtask

    function automatic logic [31:0] ctrlWord(input bit enable, input bit clearWrap);
        return (32'(1) << 9) | (32'(clearWrap) << 8) | (32'(refLast) << 1) | 32'(enable);
    endfunction

    task automatic setPat(input int i, input logic [9:0] v);
        int e;
        applyStimulus(BASE + 32'(8 + 4 * i), {22'h3FFFFF, v}, e);
        refPat[i] = v;
    endtask

    task automatic setPeriod(input int p);
        int e;
        applyStimulus(BASE + 32'd4, 32'(p), e);
        refPeriod = p;
    endtask

    task automatic startRun(output int t);
        wrCyc.delete();
        wrData.delete();
        wrAddr.delete();
        applyStimulus(BASE, ctrlWord(1'b1, 1'b1), t);
        refWrap = 1'b0;
    endtask

    task automatic stopRun(output int d);
        applyStimulus(BASE, ctrlWord(1'b0, 1'b0), d);
        repeat (4) @(negedge clk);
    endtask

    // Reference: predicts every LED write (cycle, data) from enable edge t and disable edge d.
    task automatic checkRun(input string tag, input int t, input int d);
        int          expCyc[$];
        logic [31:0] expData[$];
        int          pe;
        int          r;
        int          c;
        int          w;
        int          idxM;
        int          n;
        logic [31:0] rd;
        pe   = (refPeriod == 0) ? 1 : refPeriod;
        idxM = 0;
        r    = t + 1;
        while (r + 1 <= d) begin
            c = r;
            while (c + 1 <= d && gntLog[c] != 1'b1) c++;
            if (c + 1 > d) break;
            w = c + 1;
            expCyc.push_back(w);
            expData.push_back(32'(refPat[idxM]));
            if (w + pe + 1 > d) break;
            if (idxM >= refLast) begin
                idxM    = 0;
                refWrap = 1'b1;
            end else begin
                idxM++;
            end
            r = w + pe + 1;
        end
        checkOutput({tag, ".count"}, 32'(wrCyc.size()), 32'(expCyc.size()));
        n = (wrCyc.size() < expCyc.size()) ? wrCyc.size() : expCyc.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.cyc%0d", tag, i), 32'(wrCyc[i] - t), 32'(expCyc[i] - t));
            checkOutput($sformatf("%s.data%0d", tag, i), wrData[i], expData[i]);
            checkOutput($sformatf("%s.addr%0d", tag, i), wrAddr[i], LED_ADDR);
        end
        readReg(BASE, rd);
        checkOutput({tag, ".ctrl"}, rd,
                    (32'(IRQ_BUILD) << 9) | (32'(refWrap) << 8) | (32'(idxM) << 4) | (32'(refLast) << 1));
        checkOutput({tag, ".irq"}, 32'(irq), 32'(IRQ_BUILD && refWrap));
        checkOutput({tag, ".busReqIdle"}, 32'(busReq), 32'd0);
    endtask

    function automatic int qCyc(input int i);
        return (i < wrCyc.size()) ? wrCyc[i] : -1000;
    endfunction

    initial begin
        int          t;
        int          d;
        int          e;
        int          lowCount;
        logic [31:0] rd;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst.busReq", 32'(busReq), 32'd0);
        checkOutput("rst.mWe", 32'(mWe), 32'd0);
        checkOutput("rst.mAddr", mAddr, 32'd0);
        checkOutput("rst.mData", mData, 32'd0);
        checkOutput("rst.irq", 32'(irq), 32'd0);
        checkOutput("rst.dataBusOut", dataBusOut, 32'd0);
        readReg(BASE, rd);
        checkOutput("rst.ctrl", rd, 32'd0);
        readReg(BASE + 32'd4, rd);
        checkOutput("rst.period", rd, 32'd0);

        // Two-pattern loop, immediate grant, PERIOD=4
        $display("[TB] two-pattern loop");
        setPat(0, 10'h3FF);
        setPat(1, 10'h155);
        setPat(2, 10'h0F0);
        setPat(3, 10'h00F);
        setPeriod(4);
        readReg(BASE + 32'd4, rd);
        checkOutput("period.readback", rd, 32'd4);
        readReg(BASE + 32'hC, rd);
        checkOutput("pat1.readback", rd, 32'h155);
        refLast = 1;
        gntMode = 1;
        startRun(t);
        @(negedge clk);
        checkOutput("loop.busReqT1", 32'(busReq), 32'd1);
        checkOutput("loop.mWeT1", 32'(mWe), 32'd0);
        repeat (29) @(negedge clk);
        stopRun(d);
        checkOutput("loop.firstAt", 32'(qCyc(0) - t), 32'd2);
        checkOutput("loop.spacing", 32'(qCyc(1) - qCyc(0)), 32'd6);
        checkOutput("loop.third", (wrData.size() > 2) ? wrData[2] : 32'hDEAD, 32'h3FF);
        checkRun("loop", t, d);

        // Grant withheld in REQ
        $display("[TB] grant wait");
        gntMode = 0;
        startRun(t);
        lowCount = 0;
        repeat (11) begin
            @(negedge clk);
            if (busReq !== 1'b1) lowCount++;
        end
        checkOutput("gntWait.busReqLow", 32'(lowCount), 32'd0);
        checkOutput("gntWait.noWrite", 32'(wrCyc.size()), 32'd0);
        gntMode = 1;
        repeat (10) @(negedge clk);
        stopRun(d);
        checkRun("gntWait", t, d);

        // Disable in COUNT after a couple of steps, then in REQ
        $display("[TB] disable and restart");
        refLast = 3;
        setPeriod(3);
        gntMode = 1;
        startRun(t);
        repeat (9) @(negedge clk);
        applyStimulus(BASE, ctrlWord(1'b0, 1'b0), d);
        @(negedge clk);
        checkOutput("disCount.busReq", 32'(busReq), 32'd0);
        repeat (8) @(negedge clk);
        checkRun("disCount", t, d);
        gntMode = 0;
        startRun(t);
        repeat (4) @(negedge clk);
        applyStimulus(BASE, ctrlWord(1'b0, 1'b0), d);
        @(negedge clk);
        checkOutput("disReq.busReq", 32'(busReq), 32'd0);
        gntMode = 1;
        repeat (8) @(negedge clk);
        checkRun("disReq", t, d);
        startRun(t);
        repeat (12) @(negedge clk);
        stopRun(d);
        checkOutput("restart.pat0", (wrData.size() > 0) ? wrData[0] : 32'hDEAD, 32'h3FF);
        checkRun("restart", t, d);

        // PERIOD=0, LAST=0
        $display("[TB] period zero");
        refLast = 0;
        setPeriod(0);
        startRun(t);
        repeat (15) @(negedge clk);
        stopRun(d);
        checkOutput("p0.spacing", 32'(qCyc(1) - qCyc(0)), 32'd3);
        checkRun("p0", t, d);
        readReg(BASE + 32'h18, rd);
        checkOutput("unmapped.read", rd, 32'd0);

        // Randomized runs
        $display("[TB] random runs");
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 4; i++) setPat(i, 10'($urandom_range(0, 1023)));
            setPeriod($urandom_range(0, 5));
            refLast = $urandom_range(0, 3);
            gntMode = 2;
            startRun(t);
            repeat ($urandom_range(20, 60)) @(negedge clk);
            stopRun(d);
            checkRun($sformatf("rand%0d", it), t, d);
        end

        // Wrap interrupt and clear
        $display("[TB] wrap interrupt");
        gntMode = 1;
        refLast = 0;
        setPeriod(1);
        startRun(t);
        repeat (10) @(negedge clk);
        stopRun(d);
        checkRun("irqRun", t, d);
        applyStimulus(BASE, ctrlWord(1'b0, 1'b1), e);
        refWrap = 1'b0;
        checkOutput("irq.cleared", 32'(irq), 32'd0);
        readReg(BASE, rd);
        checkOutput("irq.wrapCleared", 32'(rd[8]), 32'd0);
        checkOutput("irq.seen", 32'(irqSeen), 32'(IRQ_BUILD));
        checkOutput("idle.outputsZero", 32'(idleBad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
